// File: rtl/dmem_sb_if.sv
// CPU-side and SRAM-side signal bundle of the store-buffered data-memory front end.
// The slave modport is the front end itself; the master modport is its environment.
interface dmem_sb_if #(
    parameter int SB_DEPTH = 4
);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic             cpu_read_i;
    logic             cpu_write_i;
    logic [7:0]       cpu_addr_i;
    logic [31:0]      cpu_wdata_i;
    logic [31:0]      cpu_rdata_o;
    logic             cpu_stall_o;
    logic             sram_en_o;
    logic             sram_we_o;
    logic [7:0]       sram_addr_o;
    logic [31:0]      sram_wdata_o;
    logic [31:0]      sram_rdata_i;
    logic [CNT_W-1:0] sb_count_o;

    modport slave (
        input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, sram_rdata_i,
        output cpu_rdata_o, cpu_stall_o, sram_en_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sb_count_o
    );

    modport master (
        output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, sram_rdata_i,
        input  cpu_rdata_o, cpu_stall_o, sram_en_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sb_count_o
    );
endinterface

// File: rtl/dmem_sb.sv
// Data-memory front end: stores land in a FIFO store buffer drained to SRAM on spare
// cycles; loads forward from the youngest matching entry or take one SRAM stall cycle.
module dmem_sb #(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_sb_if.slave    bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [7:0]         addr_mem [SB_DEPTH];
    logic [31:0]        data_mem [SB_DEPTH];

    logic [PTR_W-1:0]   age_idx [SB_DEPTH];
    logic [SB_DEPTH-1:0] age_match;
    logic               hit;
    logic [31:0]        hit_data;
    logic               full, empty;
    logic               enq, pop, drain_ok;

    // age_idx[k] is the k-th oldest slot; pointer arithmetic wraps naturally.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_age
            assign age_idx[gi]   = head_reg + PTR_W'(gi);
            assign age_match[gi] = (CNT_W'(gi) < count_reg) &&
                                   (addr_mem[age_idx[gi]] == bus.cpu_addr_i);
        end
    endgenerate

    // Later (younger) matches overwrite earlier ones, so the youngest store wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (age_match[i]) begin
                hit      = 1'b1;
                hit_data = data_mem[age_idx[i]];
            end
        end
    end

    assign full  = (count_reg == CNT_W'(SB_DEPTH));
    assign empty = (count_reg == '0);

    always_comb begin
        state_next       = state_reg;
        enq              = 1'b0;
        pop              = 1'b0;
        drain_ok         = 1'b0;
        bus.cpu_rdata_o  = '0;
        bus.cpu_stall_o  = 1'b0;
        bus.sram_en_o    = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sb_count_o   = count_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cpu_write_i) begin
                    if (!full) begin
                        enq = 1'b1;
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        drain_ok        = 1'b1;
                    end
                end else if (bus.cpu_read_i) begin
                    if (hit) begin
                        bus.cpu_rdata_o = hit_data;
                        drain_ok        = 1'b1;
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        bus.sram_en_o   = 1'b1;
                        bus.sram_addr_o = bus.cpu_addr_i;
                        state_next      = LOAD_WAIT;
                    end
                end else begin
                    drain_ok = 1'b1;
                end
            end
            LOAD_WAIT: begin
                bus.cpu_rdata_o = bus.sram_rdata_i;
                drain_ok        = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (drain_ok && !empty) begin
            pop              = 1'b1;
            bus.sram_en_o    = 1'b1;
            bus.sram_we_o    = 1'b1;
            bus.sram_addr_o  = addr_mem[head_reg];
            bus.sram_wdata_o = data_mem[head_reg];
        end

        // Reset silences every output and blocks any SRAM write or enqueue.
        if (rst) begin
            state_next       = IDLE;
            enq              = 1'b0;
            pop              = 1'b0;
            bus.cpu_rdata_o  = '0;
            bus.cpu_stall_o  = 1'b0;
            bus.sram_en_o    = 1'b0;
            bus.sram_we_o    = 1'b0;
            bus.sram_addr_o  = '0;
            bus.sram_wdata_o = '0;
            bus.sb_count_o   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (enq) tail_reg <= tail_reg + PTR_W'(1);
            if (pop) head_reg <= head_reg + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= bus.cpu_addr_i;
            data_mem[tail_reg] <= bus.cpu_wdata_i;
        end
    end
endmodule

// File: tb/tb_dmem_sb.sv
// Bench for dmem_sb: a queue-based store-buffer model checked every cycle, an SRAM model,
// and directed scenarios with hand-computed literal expectations.
module tb_dmem_sb;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_sb_if #(.SB_DEPTH(DEPTH)) bus ();
    dmem_sb #(.SB_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM: registered read, write on enable+we
    logic [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (bus.sram_en_o && !bus.sram_we_o) bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
        if (bus.sram_en_o && bus.sram_we_o)  sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
    end

    // Behavioural model: buffer as a queue, memory as the model's own view of SRAM
    typedef struct packed { logic [7:0] addr; logic [31:0] data; } entry_t;
    entry_t      mq[$];
    logic [31:0] ref_mem [256];
    bit          m_wait = 0;
    logic [7:0]  m_load_addr = '0;
    bit act_clear, act_enq, act_pop, act_wait;

    always @(negedge clk) begin
        logic [31:0] e_rdata, e_wdata;
        logic [7:0]  e_addr;
        bit e_stall, e_en, e_we, drain, found;
        int e_count;
        e_rdata = '0; e_wdata = '0; e_addr = '0;
        e_stall = 0; e_en = 0; e_we = 0; drain = 0; found = 0;
        act_clear = 0; act_enq = 0; act_pop = 0; act_wait = 0;
        e_count = mq.size();
        if (rst) begin
            act_clear = 1;
            e_count = 0;
        end else if (m_wait) begin
            e_rdata = ref_mem[m_load_addr];
            drain = 1;
        end else if (bus.cpu_write_i) begin
            if (mq.size() < DEPTH) act_enq = 1;
            else begin e_stall = 1; drain = 1; end
        end else if (bus.cpu_read_i) begin
            for (int i = mq.size() - 1; i >= 0 && !found; i--) begin
                if (mq[i].addr == bus.cpu_addr_i) begin
                    found = 1;
                    e_rdata = mq[i].data;
                end
            end
            if (found) drain = 1;
            else begin
                e_stall = 1; e_en = 1; e_addr = bus.cpu_addr_i; act_wait = 1;
            end
        end else begin
            drain = 1;
        end
        if (!rst && drain && mq.size() > 0) begin
            act_pop = 1;
            e_en = 1; e_we = 1;
            e_addr = mq[0].addr; e_wdata = mq[0].data;
        end
        check("rdata", bus.cpu_rdata_o, e_rdata);
        check("stall", 32'(bus.cpu_stall_o), 32'(e_stall));
        check("sram_en", 32'(bus.sram_en_o), 32'(e_en));
        check("sram_we", 32'(bus.sram_we_o), 32'(e_we));
        check("sram_addr", 32'(bus.sram_addr_o), 32'(e_addr));
        check("sram_wdata", bus.sram_wdata_o, e_wdata);
        check("count", 32'(bus.sb_count_o), 32'(e_count));
        // enqueue and drain must never share a cycle
        if (act_enq) check("enq_pop_overlap", 32'(bus.sram_en_o && bus.sram_we_o), 32'd0);
    end

    always @(posedge clk) begin
        if (act_clear) begin
            mq.delete();
            m_wait = 0;
        end else begin
            if (act_pop) begin
                ref_mem[mq[0].addr] = mq[0].data;
                void'(mq.pop_front());
            end
            if (act_enq) mq.push_back('{addr: bus.cpu_addr_i, data: bus.cpu_wdata_i});
            if (act_wait) m_load_addr = bus.cpu_addr_i;
            m_wait = act_wait;
        end
    end

    task automatic drive(input bit r, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; bus.cpu_read_i = rd; bus.cpu_write_i = wr;
        bus.cpu_addr_i = a; bus.cpu_wdata_i = d;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_mem[8'h20] = 32'hDEADBEEF;
        ref_mem[8'h20]  = 32'hDEADBEEF;
        bus.sram_rdata_i = '0;
        bus.cpu_read_i = 0; bus.cpu_write_i = 0;
        bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
            mid;
            check("rst_en", 32'(bus.sram_en_o), 32'd0);
            check("rst_count", 32'(bus.sb_count_o), 32'd0);
        end
        drive(0, 0, 0, 8'h00, 32'h0);
        mid; check("first_idle_en", 32'(bus.sram_en_o), 32'd0);

        // store then forwarded load
        drive(0, 0, 1, 8'h10, 32'h11223344);
        mid; check("st_stall", 32'(bus.cpu_stall_o), 32'd0);
        drive(0, 1, 0, 8'h10, 32'h0);
        mid;
        check("hit_rdata", bus.cpu_rdata_o, 32'h11223344);
        check("hit_stall", 32'(bus.cpu_stall_o), 32'd0);
        check("hit_drain_we", 32'(bus.sram_we_o), 32'd1);
        check("hit_drain_addr", 32'(bus.sram_addr_o), 32'h10);

        // load miss
        drive(0, 0, 0, 8'h00, 32'h0);
        drive(0, 1, 0, 8'h20, 32'h0);
        mid;
        check("miss_stall", 32'(bus.cpu_stall_o), 32'd1);
        check("miss_en", 32'(bus.sram_en_o), 32'd1);
        check("miss_we", 32'(bus.sram_we_o), 32'd0);
        check("miss_addr", 32'(bus.sram_addr_o), 32'h20);
        drive(0, 1, 0, 8'h20, 32'h0);
        mid;
        check("miss_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);
        check("miss_done_stall", 32'(bus.cpu_stall_o), 32'd0);

        // fill buffer, 5th store stalls with a forced drain
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 8'(i), 32'hA0 + 32'(i));
            mid; check("fill_no_write", 32'(bus.sram_en_o), 32'd0);
        end
        drive(0, 0, 1, 8'h05, 32'hA5);
        mid;
        check("full_count", 32'(bus.sb_count_o), 32'd4);
        check("full_stall", 32'(bus.cpu_stall_o), 32'd1);
        check("full_drain_addr", 32'(bus.sram_addr_o), 32'h01);
        check("full_drain_we", 32'(bus.sram_we_o), 32'd1);
        drive(0, 0, 1, 8'h05, 32'hA5);
        mid; check("retry_stall", 32'(bus.cpu_stall_o), 32'd0);
        drive(0, 0, 0, 8'h00, 32'h0);
        mid; check("after_retry_count", 32'(bus.sb_count_o), 32'd4);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 8'h00, 32'h0);

        // duplicate addresses: youngest forwards, drain in order
        drive(0, 0, 1, 8'h30, 32'hAAAA0001);
        drive(0, 0, 1, 8'h30, 32'hBBBB0002);
        drive(0, 1, 0, 8'h30, 32'h0);
        mid;
        check("dup_rdata", bus.cpu_rdata_o, 32'hBBBB0002);
        check("dup_drain_a", bus.sram_wdata_o, 32'hAAAA0001);
        drive(0, 0, 0, 8'h00, 32'h0);
        mid; check("dup_drain_b", bus.sram_wdata_o, 32'hBBBB0002);
        drive(0, 0, 0, 8'h00, 32'h0);
        mid; check("dup_final_mem", sram_mem[8'h30], 32'hBBBB0002);

        // reset during LOAD_WAIT with two buffered stores
        drive(0, 0, 1, 8'h40, 32'h40404040);
        drive(0, 0, 1, 8'h41, 32'h41414141);
        drive(0, 1, 0, 8'h50, 32'h0);
        mid; check("rstw_miss_stall", 32'(bus.cpu_stall_o), 32'd1);
        drive(1, 1, 0, 8'h50, 32'h0);
        mid; check("rstw_en", 32'(bus.sram_en_o), 32'd0);
        drive(0, 0, 0, 8'h00, 32'h0);
        mid;
        check("rstw_count", 32'(bus.sb_count_o), 32'd0);
        check("rstw_stall", 32'(bus.cpu_stall_o), 32'd0);
        check("rstw_rdata", bus.cpu_rdata_o, 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 32'h0);
        mid;
        check("rstw_no_write", sram_mem[8'h40], 32'd0);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (sram_mem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
